// File: rtl/pwm_decoder_if.sv
// pwm_decoder_if -- signal bundle between a PWM decoder and its user.
//   pwm_in    : raw PWM pin (asynchronous to clk)
//   clear     : synchronous clear of results, flags and measurement FSM
//   duty      : floor(high_time*256/period), 0 or 255 when stuck
//   period    : cycles between consecutive rising edges
//   high_time : cycles from a rising edge to the following falling edge
//   valid     : one-cycle pulse when duty/period/high_time update
//   stuck     : line has been static for TIMEOUT cycles
//   overrun   : sticky, a measurement was dropped because the divider was busy
// master = the block driving the pin and reading results; slave = the decoder.
interface pwm_decoder_if #(
    parameter int CNT_W = 24
);
    logic             pwm_in;
    logic             clear;
    logic [7:0]       duty;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             stuck;
    logic             overrun;

    modport master (
        output pwm_in, clear,
        input  duty, period, high_time, valid, stuck, overrun
    );

    modport slave (
        input  pwm_in, clear,
        output duty, period, high_time, valid, stuck, overrun
    );
endinterface

// File: rtl/pwm_decoder.sv
// pwm_decoder -- measures a PWM waveform: period, high time and 8-bit duty.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : pwm_decoder_if.slave (pwm_in, clear in; duty, period, high_time,
//         valid, stuck, overrun out)
// The pin is synchronised, edges are timed with a free-running counter that
// restarts on every rise, and duty is produced by an 8-step restoring divider.
module pwm_decoder #(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 2000000
) (
    input  logic          clk,
    input  logic          rst,
    pwm_decoder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ---------------- input path ----------------
    // Two sync flops, one edge register, then registered edge flags. Both
    // edges see the same pipeline, so measured durations are exact.
    logic [1:0] sync;
    logic       line_d;
    logic       rise;
    logic       fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            line_d <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync   <= {sync[0], bus.pwm_in};
            line_d <= sync[1];
            rise   <= sync[1] & ~line_d;
            fall   <= ~sync[1] & line_d;
        end
    end

    // ---------------- edge timer ----------------
    // Loads 1 on the edge ending a rise cycle, so in any later cycle it equals
    // the number of cycles since that rise.
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 cnt <= '0;
        else if (rise)           cnt <= CNT_ONE;
        else if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
    end

    // ---------------- measurement FSM ----------------
    state_t state, state_nxt;
    logic   timeout;
    logic   meas_done;
    logic   h_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        meas_done = 1'b0;
        h_load    = 1'b0;
        if (bus.clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (rise) state_nxt = HIGH;   // falls here are ignored
                HIGH: begin
                    if (fall) begin
                        h_load    = 1'b1;
                        state_nxt = LOW;
                    end else if (cnt >= TO_VAL) begin
                        timeout   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        meas_done = 1'b1;
                        state_nxt = HIGH;
                    end else if (cnt >= TO_VAL) begin
                        timeout   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    logic [CNT_W-1:0] h_lat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         h_lat <= '0;
        else if (h_load) h_lat <= cnt;
    end

    // ---------------- restoring divider ----------------
    // high < period always, so the remainder stays below period and the
    // doubled remainder fits in CNT_W+1 bits.
    logic             busy;
    logic [2:0]       iter;
    logic [CNT_W-1:0] rem;
    logic [7:0]       quo;
    logic [CNT_W-1:0] p_op;
    logic [CNT_W-1:0] h_op;
    logic [CNT_W:0]   rem2;
    logic             ge;
    logic [CNT_W-1:0] rem_nxt;
    logic [7:0]       quo_nxt;
    logic             start;
    logic             drop;
    logic             div_done;

    always_comb begin
        rem2     = {rem, 1'b0};
        ge       = rem2 >= {1'b0, p_op};
        rem_nxt  = ge ? CNT_W'(rem2 - {1'b0, p_op}) : CNT_W'(rem2);
        quo_nxt  = {quo[6:0], ge};
        start    = meas_done & ~busy;
        drop     = meas_done & busy;
        div_done = busy & (iter == 3'd7);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            iter <= '0;
            rem  <= '0;
            quo  <= '0;
            p_op <= '0;
            h_op <= '0;
        end else if (bus.clear) begin
            busy <= 1'b0;
            iter <= '0;
        end else if (start) begin
            busy <= 1'b1;
            iter <= '0;
            rem  <= h_lat;
            quo  <= '0;
            p_op <= cnt;
            h_op <= h_lat;
        end else if (busy) begin
            rem  <= rem_nxt;
            quo  <= quo_nxt;
            iter <= iter + 3'd1;
            if (iter == 3'd7) busy <= 1'b0;
        end
    end

    // ---------------- result registers ----------------
    logic [7:0]       duty_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_r;
    logic             valid_r;
    logic             stuck_r;
    logic             overrun_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_r    <= '0;
            period_r  <= '0;
            high_r    <= '0;
            valid_r   <= 1'b0;
            stuck_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else if (bus.clear) begin
            duty_r    <= '0;
            period_r  <= '0;
            high_r    <= '0;
            valid_r   <= 1'b0;
            stuck_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (rise) stuck_r <= 1'b0;
            if (drop) overrun_r <= 1'b1;
            // Timeout takes priority over a divider finishing in the same cycle.
            if (timeout) begin
                stuck_r  <= 1'b1;
                period_r <= '0;
                high_r   <= '0;
                duty_r   <= sync[1] ? 8'hFF : 8'h00;
                valid_r  <= 1'b1;
            end else if (div_done) begin
                duty_r   <= quo_nxt;
                period_r <= p_op;
                high_r   <= h_op;
                valid_r  <= 1'b1;
            end
        end
    end

    assign bus.duty      = duty_r;
    assign bus.period    = period_r;
    assign bus.high_time = high_r;
    assign bus.valid     = valid_r;
    assign bus.stuck     = stuck_r;
    assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder -- drives PWM segments into pwm_decoder and checks every
// valid pulse against an event-level model: each rising edge of the pin closes
// a period (rise-to-rise, high = rise-to-fall), the result appears 12 cycles
// after the closing rise unless a result was accepted less than 9 cycles
// earlier, and a line static for TIMEOUT cycles after a rise reports stuck.
module tb_pwm_decoder;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_decoder_if #(.CNT_W(CNT_W)) bus ();

    pwm_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int cyc;
        int duty;
        int per;
        int hi;
        bit stk;
    } exp_t;

    exp_t sb[$];
    int   mstate   = 0;      // 0 waiting for rise, 1 high seen, 2 low seen
    int   last_rise = 0;
    int   fall_c   = 0;
    int   last_acc = -1000;
    bit   cur      = 1'b0;
    bit   exp_ovr  = 1'b0;

    task automatic model_reset();
        sb.delete();
        mstate   = 0;
        last_acc = -1000;
        exp_ovr  = 1'b0;
    endtask

    task automatic set_pin(input bit v);
        exp_t e;
        int   c;
        c = cyc;
        if (v != cur) begin
            bus.pwm_in = v;
            cur = v;
            if (v) begin
                if (mstate == 2) begin
                    if (c - last_acc >= 9) begin
                        e.cyc  = c + 12;
                        e.per  = c - last_rise;
                        e.hi   = fall_c - last_rise;
                        e.duty = (e.hi * 256) / e.per;
                        e.stk  = 1'b0;
                        sb.push_back(e);
                        last_acc = c;
                    end else begin
                        exp_ovr = 1'b1;
                    end
                end
                mstate    = 1;
                last_rise = c;
            end else if (mstate == 1) begin
                fall_c = c;
                mstate = 2;
            end
        end
    endtask

    task automatic hold(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            if (mstate != 0 && cyc - last_rise == TIMEOUT + 2) begin
                e.cyc  = last_rise + TIMEOUT + 4;
                e.per  = 0;
                e.hi   = 0;
                e.duty = cur ? 255 : 0;
                e.stk  = 1'b1;
                sb.push_back(e);
                mstate = 0;
            end
        end
    endtask

    task automatic seg(input bit v, input int n);
        set_pin(v);
        hold(n);
    endtask

    // ---------------- result monitor ----------------
    exp_t em;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    em = sb.pop_front();
                    chk("valid_cycle", cyc, em.cyc);
                    chk("duty", bus.duty, em.duty);
                    chk("period", bus.period, em.per);
                    chk("high_time", bus.high_time, em.hi);
                    chk("stuck", bus.stuck, em.stk);
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("valid_missing", 0, 1);
                em = sb.pop_front();
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int p;
        int h;
        bus.pwm_in = 1'b0;
        bus.clear  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_duty", bus.duty, 0);
        chk("rst_period", bus.period, 0);
        chk("rst_high", bus.high_time, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_stuck", bus.stuck, 0);
        chk("rst_overrun", bus.overrun, 0);
        rst = 1'b0;
        hold(5);

        // 1000 / 250 -> duty 64
        for (int i = 0; i < 4; i++) begin
            seg(1, 250);
            seg(0, 750);
        end
        chk("duty_1000_250", bus.duty, 64);
        chk("period_1000", bus.period, 1000);

        // boundary duties
        for (int i = 0; i < 3; i++) begin seg(1, 1); seg(0, 255); end
        hold(15);
        chk("duty_256_1", bus.duty, 1);
        for (int i = 0; i < 3; i++) begin seg(1, 255); seg(0, 1); end
        hold(15);
        chk("duty_256_255", bus.duty, 255);
        for (int i = 0; i < 3; i++) begin seg(1, 255); seg(0, 745); end
        hold(15);
        chk("duty_1000_255", bus.duty, 65);

        // stuck high, then recovery
        seg(1, TIMEOUT + 10);
        chk("stuck_set", bus.stuck, 1);
        chk("stuck_duty", bus.duty, 255);
        chk("stuck_period", bus.period, 0);
        seg(0, 100);
        seg(1, 300);
        chk("stuck_cleared", bus.stuck, 0);
        seg(0, 700);
        seg(1, 20);
        chk("resume_duty", bus.duty, 76);
        seg(0, 50);

        // faster than the divider -> overrun
        for (int i = 0; i < 10; i++) begin seg(1, 3); seg(0, 3); end
        seg(1, 3);
        seg(0, 30);
        chk("ovr_duty", bus.duty, 128);
        chk("ovr_set", bus.overrun, 1);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        model_reset();
        chk("clr_duty", bus.duty, 0);
        chk("clr_period", bus.period, 0);
        chk("clr_high", bus.high_time, 0);
        chk("clr_overrun", bus.overrun, 0);
        chk("clr_stuck", bus.stuck, 0);
        hold(5);

        // randomized periods, including some faster than the divider
        for (int i = 0; i < 30; i++) begin
            p = (i % 5 == 4) ? int'($urandom_range(2, 12)) : int'($urandom_range(9, 400));
            h = int'($urandom_range(1, p - 1));
            seg(1, h);
            seg(0, p - h);
        end
        hold(20);
        chk("rand_overrun", bus.overrun, exp_ovr);
        seg(0, 50);

        // reset in the middle of a divide
        seg(1, 6);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.valid, 0);
        chk("mid_rst_duty", bus.duty, 0);
        chk("mid_rst_period", bus.period, 0);
        model_reset();
        bus.pwm_in = 1'b0;
        cur = 1'b0;
        hold(3);
        rst = 1'b0;
        hold(20);
        seg(1, 200);
        seg(0, 300);
        seg(1, 200);
        seg(0, 300);
        chk("post_rst_duty", bus.duty, 102);

        hold(30);
        chk("queue_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
